// File: rtl/lbp_engine_param.sv
// 3x3 LBP engine over a 2**ROW_W x 2**COL_W image; LBP_UNIFORM_EN selects the uniform rotation-invariant code.
// Latency: 11 cycles for a row-start pixel, 5 cycles for each following pixel, 1 cycle per border write.
// Backpressure: gray_ready low holds the read sequence; accepted reads still land one cycle later.
module lbp_engine_param #(
  parameter int COL_W       = 7,
  parameter int ROW_W       = 7,
  parameter int DATA_W      = 8,
  parameter int ZERO_BORDER = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [COL_W+ROW_W-1:0] gray_addr,
  output logic                   gray_req,
  input  logic                   gray_ready,
  input  logic [DATA_W-1:0]      gray_data,
  output logic [COL_W+ROW_W-1:0] lbp_addr,
  output logic                   lbp_valid,
  output logic [7:0]             lbp_data,
  output logic                   finish
);

  localparam int W = 1 << COL_W;
  localparam int H = 1 << ROW_W;
  localparam bit HAS_INTERIOR = (W > 2) && (H > 2);
  localparam logic [COL_W-1:0] C_LAST_IN = COL_W'(W - 2);
  localparam logic [ROW_W-1:0] R_LAST_IN = ROW_W'(H - 2);
  localparam logic [COL_W-1:0] C_MAX = '1;
  localparam logic [ROW_W-1:0] R_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SHIFT, S_CALC, S_BORDER, S_DONE
  } state_t;

  state_t state;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [1:0]       iss_r, iss_c;
  logic             iss_done;
  logic             cap_vld;
  logic [1:0]       cap_r, cap_c;
  logic [1:0]       bph;
  // window indexed [col][row], col 0 = c-1, row 0 = r-1
  logic [2:0][2:0][DATA_W-1:0] win, win_nxt;

  logic             req_en;
  logic             accept;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] brow;
  logic [COL_W-1:0] bcol;
  logic [7:0]       code_nxt;

  assign req_en    = ((state == S_FILL) || (state == S_SHIFT)) && !iss_done;
  assign gray_req  = req_en & gray_ready;
  assign accept    = gray_req;
  assign rd_row    = row - ROW_W'(1) + ROW_W'(iss_r);
  assign rd_col    = col - COL_W'(1) + COL_W'(iss_c);
  assign gray_addr = req_en ? {rd_row, rd_col} : '0;
  assign brow      = lbp_addr[COL_W +: ROW_W];
  assign bcol      = lbp_addr[COL_W-1:0];

  always_comb begin
    win_nxt = win;
    if (cap_vld) win_nxt[cap_c][cap_r] = gray_data;
  end

  function automatic logic [7:0] raw_code(input logic [2:0][2:0][DATA_W-1:0] w);
    logic [DATA_W-1:0] ctr;
    ctr = w[1][1];
    raw_code = {w[2][2] >= ctr, w[1][2] >= ctr, w[0][2] >= ctr, w[2][1] >= ctr,
                w[0][1] >= ctr, w[2][0] >= ctr, w[1][0] >= ctr, w[0][0] >= ctr};
  endfunction

`ifdef LBP_UNIFORM_EN
  function automatic logic [7:0] map_code(input logic [7:0] b);
    logic [7:0] ring;
    logic [3:0] trans;
    logic [3:0] ones;
    // clockwise walk around the neighbourhood starting at top-left
    ring  = {b[3], b[5], b[6], b[7], b[4], b[2], b[1], b[0]};
    trans = '0;
    ones  = '0;
    for (int i = 0; i < 8; i++) begin
      trans = trans + {3'b000, ring[i] ^ ring[(i + 1) % 8]};
      ones  = ones + {3'b000, b[i]};
    end
    map_code = (trans <= 4'd2) ? {4'b0000, ones} : 8'd9;
  endfunction
`else
  function automatic logic [7:0] map_code(input logic [7:0] b);
    map_code = b;
  endfunction
`endif

  assign code_nxt = map_code(raw_code(win_nxt));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      iss_r     <= '0;
      iss_c     <= '0;
      iss_done  <= 1'b0;
      cap_vld   <= 1'b0;
      cap_r     <= '0;
      cap_c     <= '0;
      bph       <= '0;
      win       <= '0;
      lbp_addr  <= '0;
      lbp_valid <= 1'b0;
      lbp_data  <= '0;
      finish    <= 1'b0;
    end else begin
      cap_vld <= accept;
      if (accept) begin
        cap_r <= iss_r;
        cap_c <= iss_c;
        if (iss_r == 2'd2) begin
          iss_r <= 2'd0;
          if (iss_c == 2'd2) iss_done <= 1'b1;
          else               iss_c    <= iss_c + 2'd1;
        end else begin
          iss_r <= iss_r + 2'd1;
        end
      end
      win <= win_nxt;

      case (state)
        S_IDLE: begin
          if (gray_ready) begin
            if (HAS_INTERIOR) begin
              state    <= S_FILL;
              row      <= ROW_W'(1);
              col      <= COL_W'(1);
              iss_r    <= 2'd0;
              iss_c    <= 2'd0;
              iss_done <= 1'b0;
            end else if (ZERO_BORDER != 0) begin
              state     <= S_BORDER;
              bph       <= 2'd0;
              lbp_valid <= 1'b1;
              lbp_addr  <= '0;
              lbp_data  <= '0;
            end else begin
              state  <= S_DONE;
              finish <= 1'b1;
            end
          end
        end

        S_FILL, S_SHIFT: begin
          // bottom-right tap is always the last read of both FILL and SHIFT
          if (cap_vld && (cap_r == 2'd2) && (cap_c == 2'd2)) begin
            state     <= S_CALC;
            lbp_valid <= 1'b1;
            lbp_addr  <= {row, col};
            lbp_data  <= code_nxt;
          end
        end

        S_CALC: begin
          lbp_valid <= 1'b0;
          lbp_addr  <= '0;
          lbp_data  <= '0;
          if (col != C_LAST_IN) begin
            state    <= S_SHIFT;
            col      <= col + COL_W'(1);
            win[0]   <= win[1];
            win[1]   <= win[2];
            iss_r    <= 2'd0;
            iss_c    <= 2'd2;
            iss_done <= 1'b0;
          end else if (row != R_LAST_IN) begin
            state    <= S_FILL;
            row      <= row + ROW_W'(1);
            col      <= COL_W'(1);
            iss_r    <= 2'd0;
            iss_c    <= 2'd0;
            iss_done <= 1'b0;
          end else if (ZERO_BORDER != 0) begin
            state     <= S_BORDER;
            bph       <= 2'd0;
            lbp_valid <= 1'b1;
          end else begin
            state  <= S_DONE;
            finish <= 1'b1;
          end
        end

        S_BORDER: begin
          lbp_data <= '0;
          case (bph)
            2'd0: begin
              if (bcol == C_MAX) begin
                bph      <= 2'd1;
                lbp_addr <= {R_MAX, COL_W'(0)};
              end else begin
                lbp_addr <= {brow, bcol + COL_W'(1)};
              end
            end
            2'd1: begin
              if (bcol != C_MAX) begin
                lbp_addr <= {brow, bcol + COL_W'(1)};
              end else if (H > 2) begin
                bph      <= 2'd2;
                lbp_addr <= {ROW_W'(1), COL_W'(0)};
              end else begin
                state     <= S_DONE;
                finish    <= 1'b1;
                lbp_valid <= 1'b0;
                lbp_addr  <= '0;
              end
            end
            2'd2: begin
              if (brow == R_LAST_IN) begin
                bph      <= 2'd3;
                lbp_addr <= {ROW_W'(1), C_MAX};
              end else begin
                lbp_addr <= {brow + ROW_W'(1), bcol};
              end
            end
            default: begin
              if (brow == R_LAST_IN) begin
                state     <= S_DONE;
                finish    <= 1'b1;
                lbp_valid <= 1'b0;
                lbp_addr  <= '0;
              end else begin
                lbp_addr <= {brow + ROW_W'(1), bcol};
              end
            end
          endcase
        end

        S_DONE: begin
          lbp_valid <= 1'b0;
          lbp_data  <= '0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
